// File: rtl/lbp_hist.sv
// ---------------------------------------------------------------------------
// lbp_hist
// ---------------------------------------------------------------------------
// Purpose:
//    This block watches the LBP core's result write port. It builds a
//    256-bin histogram of LBP codes for one IMG_W x IMG_W frame. Once the
//    core signals finish, it streams bins 0..255 out over a valid/ready
//    interface to the feature-vector / classifier stage.
//
// Ports:
//    clk         rising-edge clock
//    reset       synchronous, active-low reset (aborts ACC or DRAIN at once)
//    lbp_valid   LBP result strobe (the same strobe that writes LBP memory)
//    lbp_addr    pixel address of the result, row*IMG_W + col
//    lbp_data    LBP code, used as the bin index
//    finish      frame complete from the LBP core (level)
//    hist_valid  drain beat valid
//    hist_ready  downstream accepts the current beat
//    hist_bin    bin index of the current beat
//    hist_count  count held in hist_bin
//    hist_total  samples accumulated this frame
//    hist_done   all 256 bins have been accepted
//
// Configuration:
//    LBP_HIST_BORDER_EXCL_EN  When defined, samples on the outer ring of
//                             the frame are not counted. The outer ring is
//                             row or col equal to 0 or IMG_W-1.
// ---------------------------------------------------------------------------
module lbp_hist #(
   parameter int IMG_W  = 128,
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lbp_valid,
   input  logic [ADDR_W-1:0] lbp_addr,
   input  logic [7:0]        lbp_data,
   input  logic              finish,
   output logic              hist_valid,
   input  logic              hist_ready,
   output logic [7:0]        hist_bin,
   output logic [CNT_W-1:0]  hist_count,
   output logic [CNT_W-1:0]  hist_total,
   output logic              hist_done
);

   localparam int               COL_W   = $clog2(IMG_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] bin_reg [256];
   logic [CNT_W-1:0] total_reg;
   logic             hist_valid_reg, hist_valid_next;
   logic             hist_done_reg, hist_done_next;
   logic [7:0]       hist_bin_reg, hist_bin_next;
   logic [CNT_W-1:0] hist_count_reg, hist_count_next;
   logic             pixel_ok;
   logic             sample_en;
   logic [255:0]     hit;

   // ------------------------------------------------------------------------
   // Pixel qualification
   // ------------------------------------------------------------------------
`ifdef LBP_HIST_BORDER_EXCL_EN
   localparam int ROW_W = ADDR_W - COL_W;

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;

   assign row = lbp_addr[ADDR_W-1:COL_W];
   assign col = lbp_addr[COL_W-1:0];
   assign pixel_ok = !((row == '0) || (row == ROW_W'(IMG_W - 1)) ||
                       (col == '0) || (col == COL_W'(IMG_W - 1)));
`else
   // Every sample counts, so the address is not needed. The unused_ net
   // keeps the port and the geometry parameter referenced.
   logic unused_cfg;

   assign unused_cfg = ^{lbp_addr, 32'(COL_W)};
   assign pixel_ok   = 1'b1;
`endif

   // Samples only count while accumulating.
   // A sample arriving in the same cycle as finish is still in ACC, so it
   // is counted.
   assign sample_en = lbp_valid && pixel_ok && (state_reg == ST_ACC);

   // ------------------------------------------------------------------------
   // Bin counters
   // ------------------------------------------------------------------------
   // Each bin has its own incrementer and decoded hit line. Because of
   // that, repeated hits on one bin in consecutive cycles accumulate
   // without any read-modify-write hazard.
   generate
      for (genvar gi = 0; gi < 256; gi++) begin : g_hit
         assign hit[gi] = sample_en && (lbp_data == 8'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) begin
            bin_reg[i] <= '0;
         end
         total_reg <= '0;
      end else begin
         for (int i = 0; i < 256; i++) begin
            if (hit[i] && (bin_reg[i] != CNT_MAX)) begin
               bin_reg[i] <= bin_reg[i] + 1'b1;
            end
         end
         if (sample_en && (total_reg != CNT_MAX)) begin
            total_reg <= total_reg + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM and registered drain outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= ST_ACC;
         hist_valid_reg <= 1'b0;
         hist_done_reg  <= 1'b0;
         hist_bin_reg   <= '0;
         hist_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         hist_valid_reg <= hist_valid_next;
         hist_done_reg  <= hist_done_next;
         hist_bin_reg   <= hist_bin_next;
         hist_count_reg <= hist_count_next;
      end
   end

   // hist_bin_reg doubles as the drain index.
   // The first DRAIN cycle has no beat up yet. It loads bin 0, and each
   // later accepted beat advances to the next bin.
   always_comb begin
      state_next      = state_reg;
      hist_valid_next = hist_valid_reg;
      hist_done_next  = hist_done_reg;
      hist_bin_next   = hist_bin_reg;
      hist_count_next = hist_count_reg;

      case (state_reg)
         ST_ACC: begin
            if (finish) begin
               state_next = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (!hist_valid_reg) begin
               hist_valid_next = 1'b1;
               hist_bin_next   = 8'd0;
               hist_count_next = bin_reg[0];
            end else if (hist_ready) begin
               if (hist_bin_reg == 8'hFF) begin
                  hist_valid_next = 1'b0;
                  hist_done_next  = 1'b1;
                  state_next      = ST_DONE;
               end else begin
                  hist_bin_next   = hist_bin_reg + 8'd1;
                  hist_count_next = bin_reg[hist_bin_next];
               end
            end
         end

         ST_DONE: begin
            // Hold until reset.
         end

         default: begin
            state_next = ST_ACC;
         end
      endcase
   end

   assign hist_valid = hist_valid_reg;
   assign hist_done  = hist_done_reg;
   assign hist_bin   = hist_bin_reg;
   assign hist_count = hist_count_reg;
   assign hist_total = total_reg;

endmodule

// File: tb/tb_lbp_hist.sv
// ---------------------------------------------------------------------------
// tb_lbp_hist
// ---------------------------------------------------------------------------
// Self-checking bench for lbp_hist.
// When frame stimulus is driven, a reference histogram is updated, and the
// 256 expected drain beats are queued. The observed beats are collected
// during the drain. Each scenario task then pops and compares them.
// ---------------------------------------------------------------------------
module tb_lbp_hist;

   localparam int IMG_W  = 128;
   localparam int ADDR_W = 14;
   localparam int CNT_W  = 15;
   localparam int NPIX   = IMG_W * IMG_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk        = 1'b0;
   logic              reset      = 1'b0;
   logic              lbp_valid  = 1'b0;
   logic [ADDR_W-1:0] lbp_addr   = '0;
   logic [7:0]        lbp_data   = '0;
   logic              finish     = 1'b0;
   logic              hist_ready = 1'b0;
   logic              hist_valid;
   logic [7:0]        hist_bin;
   logic [CNT_W-1:0]  hist_count;
   logic [CNT_W-1:0]  hist_total;
   logic              hist_done;

   lbp_hist #(
      .IMG_W (IMG_W),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .lbp_valid (lbp_valid),
      .lbp_addr  (lbp_addr),
      .lbp_data  (lbp_data),
      .finish    (finish),
      .hist_valid(hist_valid),
      .hist_ready(hist_ready),
      .hist_bin  (hist_bin),
      .hist_count(hist_count),
      .hist_total(hist_total),
      .hist_done (hist_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int bin;
      int cnt;
      int cyc;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    exp_bins[256];
   int    exp_total;
   int    n_checks = 0;
   int    n_fail   = 0;
   int    done_cyc;
   int    stall_breaks;
   int    done_early;
   bit    timed_out;

   // Reference rule for which pixels contribute to the histogram.
   function automatic bit excluded(input int a);
`ifdef LBP_HIST_BORDER_EXCL_EN
      int r;
      int c;
      r = a / IMG_W;
      c = a % IMG_W;
      return (r == 0) || (r == IMG_W - 1) || (c == 0) || (c == IMG_W - 1);
`else
      return (a < 0);
`endif
   endfunction

   task automatic model_clear();
      for (int b = 0; b < 256; b++) exp_bins[b] = 0;
      exp_total = 0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      lbp_valid  = 1'b0;
      finish     = 1'b0;
      hist_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
   endtask

   // Drives n samples. The data source is selected by mode:
   //    0 = constant dval, 1 = addr[7:0], 2 = random.
   // Then finish is raised, either with the last sample or on its own
   // cycle. The task returns just after the edge that moves the DUT into
   // DRAIN, and pushes the expected drain beats.
   task automatic feed_frame(input int n, input int mode, input logic [7:0] dval,
                             input int base_addr, input bit overlap);
      for (int i = 0; i < n; i++) begin
         int          a;
         logic [7:0]  d;
         a = base_addr + i;
         case (mode)
            1:       d = 8'(a);
            2:       d = 8'($urandom_range(0, 255));
            default: d = dval;
         endcase
         lbp_valid = 1'b1;
         lbp_addr  = ADDR_W'(a);
         lbp_data  = d;
         finish    = overlap && (i == n - 1);
         if (!excluded(a)) begin
            if (exp_bins[d] < CMAX) exp_bins[d]++;
            if (exp_total < CMAX)   exp_total++;
         end
         @(posedge clk);
         #1;
      end
      lbp_valid = 1'b0;
      if (!overlap) begin
         finish = 1'b1;
         @(posedge clk);
         #1;
      end
      finish = 1'b0;
      for (int b = 0; b < 256; b++) begin
         beat_t e;
         e.bin = b;
         e.cnt = exp_bins[b];
         e.cyc = b + 1;
         exp_q.push_back(e);
      end
   endtask

   // Collects drain beats until hist_done or until the cycle budget runs out.
   // Cycle 0 is the first cycle in DRAIN.
   // random_ready toggles hist_ready pseudo-randomly. inject drives
   // lbp_valid and finish pulses, which the DUT must ignore.
   task automatic drain_collect(input bit random_ready, input bit inject);
      int               c;
      int               last_acc;
      logic             prev_stall;
      logic [7:0]       pb;
      logic [CNT_W-1:0] pc;
      got_q.delete();
      done_cyc     = -1;
      stall_breaks = 0;
      done_early   = 0;
      timed_out    = 1'b0;
      c            = 0;
      last_acc     = -1;
      prev_stall   = 1'b0;
      pb           = '0;
      pc           = '0;
      forever begin
         if (hist_done === 1'b1) begin
            done_cyc = c;
            if (last_acc != 255) done_early++;
            break;
         end
         if (prev_stall && ((hist_bin !== pb) || (hist_count !== pc))) stall_breaks++;
         hist_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         lbp_valid  = inject && (c % 3 == 0);
         lbp_data   = 8'h03;
         lbp_addr   = ADDR_W'(IMG_W * 3 + 5);
         finish     = inject && (c % 5 == 0);
         if ((hist_valid === 1'b1) && hist_ready) begin
            beat_t g;
            g.bin = int'(hist_bin);
            g.cnt = int'(hist_count);
            g.cyc = c;
            got_q.push_back(g);
            last_acc = int'(hist_bin);
         end
         prev_stall = (hist_valid === 1'b1) && !hist_ready;
         pb         = hist_bin;
         pc         = hist_count;
         @(posedge clk);
         #1;
         c++;
         if (c > 3000) begin
            timed_out = 1'b1;
            break;
         end
      end
      hist_ready = 1'b0;
      lbp_valid  = 1'b0;
      finish     = 1'b0;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", hist_valid); end
      n_checks++;
      if (hist_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", hist_done); end
      n_checks++;
      if (hist_bin !== 8'd0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", hist_bin); end
      n_checks++;
      if (hist_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", hist_count); end
      n_checks++;
      if (hist_total !== '0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", hist_total); end
      $display("test_reset: outputs sampled after reset");
   endtask

   task automatic test_single_bin();
      do_reset();
      feed_frame(NPIX, 0, 8'h5A, 0, 1'b0);
      n_checks++;
      if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL single_first_cycle_valid: got %b want 0", hist_valid); end
      drain_collect(1'b0, 1'b0);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL single_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt) || (g.cyc !== e.cyc))
               begin n_fail++; $display("FAIL single_beat: got bin %0d cnt %0d cyc %0d want bin %0d cnt %0d cyc %0d", g.bin, g.cnt, g.cyc, e.bin, e.cnt, e.cyc); end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL single_extra_beats: got %0d want 0", got_q.size()); end
      n_checks++;
      if (done_cyc != 257) begin n_fail++; $display("FAIL single_done_cycle: got %0d want 257", done_cyc); end
      n_checks++;
      if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_at_done: got %b want 0", hist_valid); end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL single_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_single_bin: frame of %0d samples on bin 0x5A drained, done at cycle %0d", NPIX, done_cyc);
   endtask

   task automatic test_addr_pattern();
      do_reset();
      feed_frame(NPIX, 1, 8'h00, 0, 1'b0);
      drain_collect(1'b0, 1'b0);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL pattern_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL pattern_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt))
               begin n_fail++; $display("FAIL pattern_beat: got bin %0d cnt %0d want bin %0d cnt %0d", g.bin, g.cnt, e.bin, e.cnt); end
         end
      end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL pattern_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_addr_pattern: lbp_data=addr[7:0] frame drained, total %0d", hist_total);
   endtask

   task automatic test_stall();
      do_reset();
      feed_frame(400, 2, 8'h00, IMG_W * 5, 1'b0);
      drain_collect(1'b1, 1'b0);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL stall_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL stall_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt))
               begin n_fail++; $display("FAIL stall_beat: got bin %0d cnt %0d want bin %0d cnt %0d", g.bin, g.cnt, e.bin, e.cnt); end
         end
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL stall_extra_beats: got %0d want 0", got_q.size()); end
      n_checks++;
      if (stall_breaks != 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes while stalled want 0", stall_breaks); end
      n_checks++;
      if (done_early != 0) begin n_fail++; $display("FAIL stall_done_early: got %0d want 0", done_early); end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL stall_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_stall: random-ready drain finished at cycle %0d", done_cyc);
   endtask

   task automatic test_finish_overlap();
      do_reset();
      feed_frame(20, 0, 8'h03, IMG_W * 2 + 10, 1'b1);
      drain_collect(1'b0, 1'b1);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL overlap_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL overlap_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt))
               begin n_fail++; $display("FAIL overlap_beat: got bin %0d cnt %0d want bin %0d cnt %0d", g.bin, g.cnt, e.bin, e.cnt); end
         end
      end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL overlap_total: got %0d want %0d", hist_total, exp_total); end
      // DONE must hold against further samples and finish pulses.
      lbp_valid = 1'b1;
      finish    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      lbp_valid = 1'b0;
      finish    = 1'b0;
      n_checks++;
      if (hist_done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b want 1", hist_done); end
      n_checks++;
      if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL done_valid: got %b want 0", hist_valid); end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL done_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_finish_overlap: bin 3 frame with finish-cycle sample and drain-phase pulses");
   endtask

   task automatic test_reset_mid_drain();
      bit found;
      do_reset();
      feed_frame(40, 1, 8'h00, 0, 1'b0);
      found = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ((hist_valid === 1'b1) && (hist_bin === 8'd100)) begin
            found = 1'b1;
            break;
         end
         hist_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL abort_reach_bin100: bin 100 beat never presented"); end
      reset = 1'b0;
      @(posedge clk);
      #1;
      hist_ready = 1'b0;
      n_checks++;
      if (hist_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", hist_valid); end
      n_checks++;
      if (hist_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", hist_done); end
      n_checks++;
      if (hist_total !== '0) begin n_fail++; $display("FAIL abort_total: got %0d want 0", hist_total); end
      n_checks++;
      if ((hist_bin !== 8'd0) || (hist_count !== '0)) begin n_fail++; $display("FAIL abort_beat: got bin %0d cnt %0d want 0 0", hist_bin, hist_count); end
      reset = 1'b1;
      model_clear();
      feed_frame(10, 0, 8'h07, IMG_W + 1, 1'b0);
      drain_collect(1'b0, 1'b0);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL abort_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL abort_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt))
               begin n_fail++; $display("FAIL abort_beat: got bin %0d cnt %0d want bin %0d cnt %0d", g.bin, g.cnt, e.bin, e.cnt); end
         end
      end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL abort_new_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_reset_mid_drain: aborted at bin 100, new frame of 10 samples on bin 7 drained");
   endtask

   task automatic test_border();
      do_reset();
      feed_frame(NPIX, 0, 8'h00, 0, 1'b0);
      drain_collect(1'b0, 1'b0);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL border_timeout: drain did not reach hist_done"); end
      for (int k = 0; k < 256; k++) begin
         beat_t e;
         beat_t g;
         e = exp_q.pop_front();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("FAIL border_beat bin %0d: got no beat, want count %0d", e.bin, e.cnt);
         end else begin
            g = got_q.pop_front();
            if ((g.bin !== e.bin) || (g.cnt !== e.cnt))
               begin n_fail++; $display("FAIL border_beat: got bin %0d cnt %0d want bin %0d cnt %0d", g.bin, g.cnt, e.bin, e.cnt); end
         end
      end
      n_checks++;
      if (int'(hist_total) !== exp_total) begin n_fail++; $display("FAIL border_total: got %0d want %0d", hist_total, exp_total); end
      $display("test_border: full frame on bin 0, total %0d", hist_total);
   endtask

   initial begin
      test_reset();
      test_single_bin();
      test_addr_pattern();
      test_stall();
      test_finish_overlap();
      test_reset_mid_drain();
      test_border();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
